// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation encodings carried on the 2-bit op port
//   state_e : controller state encodings
//   ITER    : iterations per operation (one result bit per cycle)
//   f_mag   : conditional two's-complement negate, used for operand
//             magnitudes and result sign fix-up
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative multiply/divide datapath (combinational).
// Optional feature: macro MDU_DIV_EN adds the restoring-divide step.
//   i_acc_hi / i_acc_lo : accumulator pair
//                         multiply: partial product high / multiplier (shifting out)
//                         divide  : partial remainder / dividend (shifting out,
//                                   quotient bits shifting in)
//   i_opnd              : multiplicand (multiply) or divisor (divide) magnitude
//   i_div               : selects the divide step (only with MDU_DIV_EN)
//   o_acc_hi / o_acc_lo : accumulator pair after this iteration
module mdu_step (
    input  logic [31:0] i_acc_hi,
    input  logic [31:0] i_acc_lo,
    input  logic [31:0] i_opnd,
`ifdef MDU_DIV_EN
    input  logic        i_div,
`endif
    output logic [31:0] o_acc_hi,
    output logic [31:0] o_acc_lo
);

    logic [32:0] w_sum;
`ifdef MDU_DIV_EN
    logic [32:0] w_shift;
    logic [31:0] w_diff;
    logic        w_ge;
`endif

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is set,
        // then shift the 65-bit {carry, hi, lo} right by one.
        w_sum    = {1'b0, i_acc_hi} + {1'b0, (i_acc_lo[0] ? i_opnd : 32'd0)};
        o_acc_hi = w_sum[32:1];
        o_acc_lo = {w_sum[0], i_acc_lo[31:1]};
`ifdef MDU_DIV_EN
        // Restoring divide: the remainder is always below the divisor, so the
        // shifted value fits in 33 bits and a successful difference in 32.
        w_shift = {i_acc_hi, i_acc_lo[31]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        w_diff  = w_shift[31:0] - i_opnd;
        if (i_div) begin
            o_acc_hi = w_ge ? w_diff : w_shift[31:0];
            o_acc_lo = {i_acc_lo[30:0], w_ge};
        end
`endif
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional feature: macro MDU_DIV_EN enables DIV/DIVU; without it a divide
// completes immediately as a divide-by-zero (lo = all ones, hi = in1).
//   clk, reset     : clock, synchronous active-high reset
//   start, op      : operation request and kind (MULT/MULTU/DIV/DIVU)
//   in1, in2       : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we   : MTHI/MTLO strobes, data on wdata
//   hi, lo         : architectural HI/LO
//   busy           : operation in flight (RUN or FIX)
//   done           : one-cycle pulse when hi/lo first show a new result
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_acc_hi;
    logic [31:0]       r_acc_lo;
    logic [31:0]       r_opnd;
    logic              r_neg_a;   // negate product or quotient
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
`ifdef MDU_DIV_EN
    logic              r_is_div;
    logic              r_neg_r;   // negate remainder (follows dividend sign)
`endif

    op_e               w_op;
    logic              w_op_div;
    logic              w_signed;
    logic              w_s1;
    logic              w_s2;
    logic [31:0]       w_mag1;
    logic [31:0]       w_mag2;
    logic              w_accept;
    logic              w_zero_path;
    logic [31:0]       w_step_hi;
    logic [31:0]       w_step_lo;
    logic [63:0]       w_prod_neg;
    logic [31:0]       w_fix_hi;
    logic [31:0]       w_fix_lo;

    // Operand decode and magnitude conversion for the sampling cycle.
    always_comb begin
        w_op     = op_e'(op);
        w_op_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
        w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
        w_s1     = w_signed & in1[31];
        w_s2     = w_signed & in2[31];
        w_mag1   = f_mag(in1, w_s1);
        w_mag2   = f_mag(in2, w_s2);
        w_accept = start & ((r_state == S_IDLE) || (r_state == S_DONE));
`ifdef MDU_DIV_EN
        w_zero_path = w_op_div & (in2 == 32'd0);
`else
        w_zero_path = w_op_div;
`endif
    end

    mdu_step u_step (
        .i_acc_hi (r_acc_hi),
        .i_acc_lo (r_acc_lo),
        .i_opnd   (r_opnd),
`ifdef MDU_DIV_EN
        .i_div    (r_is_div),
`endif
        .o_acc_hi (w_step_hi),
        .o_acc_lo (w_step_lo)
    );

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        w_prod_neg = 64'd0 - {r_acc_hi, r_acc_lo};
        w_fix_hi   = r_neg_a ? w_prod_neg[63:32] : r_acc_hi;
        w_fix_lo   = r_neg_a ? w_prod_neg[31:0]  : r_acc_lo;
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            w_fix_lo = f_mag(r_acc_lo, r_neg_a);
            w_fix_hi = f_mag(r_acc_hi, r_neg_r);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = w_zero_path ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(ITER - 1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_neg_a  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_neg_a  <= w_s1 ^ w_s2;
`ifdef MDU_DIV_EN
            r_is_div <= w_op_div;
            r_neg_r  <= w_s1;
`endif
            // Dividend / multiplier go in the low half so they shift out
            // one bit per iteration.
            if (w_op_div) begin
                r_acc_lo <= w_mag1;
                r_opnd   <= w_mag2;
            end else begin
                r_acc_lo <= w_mag2;
                r_opnd   <= w_mag1;
            end
            if (w_zero_path) begin
                r_hi <= in1;
                r_lo <= 32'hFFFF_FFFF;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: begin
                    // Only reached when not busy; start would have been accepted.
                    if (hi_we && !start) r_hi <= wdata;
                    if (lo_we && !start) r_lo <= wdata;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == S_RUN) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] in1, in2, wdata, hi, lo;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: architectural results from plain integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 34;
        eh  = 32'd0;
        el  = 32'd0;
        case (o)
            2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF; lat = 1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    eh = r[31:0]; el = q[31:0];
                end else begin
                    up = {32'd0, a} / {32'd0, b}; el = up[31:0];
                    up = {32'd0, a} % {32'd0, b}; eh = up[31:0];
                end
`else
                eh = a; el = 32'hFFFF_FFFF; lat = 1;
`endif
            end
        endcase
    endfunction

    // Starts an op in the current cycle (T) and checks every cycle to T+lat.
    // Returns #1 after the edge into the DONE cycle, so a following call is
    // back-to-back. mt_start: MTHI/MTLO raised alongside start (must be dropped).
    // poke: at T+5 raise MTHI/MTLO and a stray start (both must be ignored).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input bit mt_start, input bit poke, input string tag);
        op = o; in1 = a; in2 = b; start = 1'b1;
        hi_we = mt_start; lo_we = mt_start; wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            chk({tag, "/busy"}, {31'd0, busy}, (k < lat) ? 32'd1 : 32'd0);
            chk({tag, "/done"}, {31'd0, done}, (k == lat) ? 32'd1 : 32'd0);
            chk({tag, "/hi"}, hi, (k < lat) ? m_hi : eh);
            chk({tag, "/lo"}, lo, (k < lat) ? m_lo : el);
            if (poke && k == 5) begin
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
                start = 1'b1; op = ~o; in1 = 32'h5555_5555; in2 = 32'd3;
            end
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        chk({tag, "/idle_done"}, {31'd0, done}, 32'd0);
        chk({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic [1:0]  o;
        int          lat, n_done;

        tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        tbl[2] = '{2'b11, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1};
        tbl[3] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
        tbl[4] = '{2'b01, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 34};
        tbl[5] = '{2'b00, 32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0,         34};
`ifdef MDU_DIV_EN
        tbl[6] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        tbl[7] = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        34};
        tbl[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
        tbl[9] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
`else
        tbl[6] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
        tbl[7] = '{2'b11, 32'd100,       32'd7,        32'd100,       32'hFFFF_FFFF, 1};
        tbl[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd7,         32'hFFFF_FFFF, 1};
        tbl[9] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1};
`endif

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; in1 = '0; in2 = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/hi", hi, 32'd0);
        chk("rst/lo", lo, 32'd0);
        chk("rst/busy", {31'd0, busy}, 32'd0);
        chk("rst/done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        idle_cycle("post_rst");

        // Table vectors, issued back-to-back from each DONE cycle.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].lat,
                   1'b0, 1'b0, $sformatf("tbl%0d", i));
        end
        idle_cycle("tbl_end");

        // MTHI/MTLO and stray start during a running op: all dropped.
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34,
               1'b0, 1'b1, "mt_busy");
        idle_cycle("mt_busy_end");

        // Idle MTHI / MTLO take effect.
        hi_we = 1'b1; wdata = 32'hA5A5_0001;
        @(posedge clk); #1; hi_we = 1'b0; m_hi = 32'hA5A5_0001;
        chk("mthi/hi", hi, m_hi);
        chk("mthi/lo", lo, m_lo);
        lo_we = 1'b1; wdata = 32'h0BAD_0002;
        @(posedge clk); #1; lo_we = 1'b0; m_lo = 32'h0BAD_0002;
        chk("mtlo/hi", hi, m_hi);
        chk("mtlo/lo", lo, m_lo);

        // Start wins over a simultaneous MTHI/MTLO.
        run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 34, 1'b1, 1'b0, "mt_start");

        // Reset at T+10 of a MULT aborts without a done pulse.
        op = 2'b00; in1 = 32'd123; in2 = 32'd456; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("abort/busy", {31'd0, busy}, 32'd0);
        chk("abort/done", {31'd0, done}, 32'd0);
        chk("abort/hi", hi, 32'd0);
        chk("abort/lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("abort/no_done", n_done, 32'd0);

        // Randomised ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 20));
                1:       a = 32'd0 - 32'($urandom_range(1, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'd0 - 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            model(o, a, b, eh, el, lat);
            run_op(o, a, b, eh, el, lat, 1'($urandom_range(0, 1)),
                   (lat > 5) ? 1'($urandom_range(0, 1)) : 1'b0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) idle_cycle($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
